mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute ALU.
- Consumes the ALU result (effective address or arithmetic result), store data, and memory-control flags.
- Performs word/half/byte loads and stores against a variable-latency data memory using a req/ready handshake, then aligns and extends load data.
- Presents a registered result to writeback and stalls execute while an access is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width.
- TIMEOUT, 64, maximum cycles to wait for dm_ready before aborting with bus_err.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute presents an instruction this cycle.
- ex_alu_out  in  32  ALU dataOut (address for memory ops, result otherwise).
- ex_rt_data  in  32  store data (rt).
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_access_size  in  2  00 word, 01 half, 10 byte; 11 illegal.
- ex_load_unsigned  in  1  zero-extend load (LBU/LHU).
- ex_rd  in  5  destination register.
- ex_reg_we  in  1  instruction writes a register.
- stall  out  1  execute must hold its outputs.
- dm_req  out  1  memory request.
- dm_we  out  1  1 = write.
- dm_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}).
- dm_wdata  out  32  store data, lane-replicated.
- dm_be  out  4  byte enables, bit3 = bits[31:24].
- dm_ready  in  1  memory accepts/completes the request this cycle.
- dm_rdata  in  32  read data, valid when dm_ready.
- wb_valid  out  1  result valid to writeback.
- wb_data  out  32  writeback value.
- wb_rd  out  5  destination register.
- wb_reg_we  out  1  register write enable.
- misalign  out  1  one-cycle pulse: rejected misaligned/illegal access.
- bus_err  out  1  one-cycle pulse: access timed out.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; timeout counter 0.
- Byte order is big-endian. Offset 0 maps to bits[31:24] and dm_be=1000.
- Half accesses: offset 0 uses be 1100, offset 2 uses be 0011.
- States:
  - IDLE: waiting for an instruction.
  - ACCESS: dm_req held.
  - RESP: one result cycle.
- IDLE, ex_valid with no mem op: next cycle wb_valid=1, wb_data=ex_alu_out, wb_rd/wb_reg_we copied. Latency 1; stall stays 0.
- IDLE, ex_valid with mem op:
  - Alignment check: word needs addr[1:0]=00; half needs addr[0]=0; size 11 is illegal.
  - On failure: next cycle misalign=1 and wb_valid=1 with wb_reg_we=0. No dm_req is issued and the state stays IDLE.
  - Otherwise: latch address, size, data, rd and flags; go to ACCESS; stall=1 combinationally in the accept cycle.
- ex_mem_read and ex_mem_write both set: treated as a store; rd write suppressed.
- ACCESS:
  - dm_req=1 with dm_we/dm_addr/dm_be/dm_wdata stable until dm_ready.
  - Store data: byte replicated to all four lanes, half replicated twice, word unchanged.
  - On dm_ready: deassert dm_req next cycle and go to RESP. Loads capture dm_rdata.
  - Counter increments each cycle without dm_ready. At count TIMEOUT-1 without ready: go to IDLE, bus_err=1, wb_valid=1, wb_reg_we=0.
- RESP:
  - wb_valid=1.
  - Loads: wb_data is the selected lane, sign- or zero-extended; wb_reg_we=latched reg_we.
  - Stores: wb_reg_we=0 and wb_data=address.
  - stall falls in this cycle. Next state is IDLE, and a new instruction may be accepted in the same cycle.
- Mem-op latency with ready in the first ACCESS cycle: accept cycle, then ACCESS, then RESP = result 2 cycles after accept.
- stall=1 for the accept cycle and all ACCESS cycles.
- ex_valid while stall=1 is ignored; execute holds its values.
- wb_valid is high for exactly one cycle per accepted instruction. misalign and bus_err are single-cycle pulses.
- reset_n asserted mid-ACCESS: immediate return to IDLE with dm_req=0. The in-flight access is dropped.

Decomposition:
- Shared package (mips_pkg):
  - Access-size encodings SZ_WORD/SZ_HALF/SZ_BYTE.
  - State enum.
  - Opcode constants LW/SW/LB/LBU/SB/LH/LHU/SH, shared with the ALU and decoder.
- Sub-module load_align: combinational lane-select plus sign/zero extension from (rdata, offset, size, unsigned). It is reused for store lane/be generation through a mode input.

Test Plan:
- Non-mem ADD: ex_alu_out=0x00000007, rd=5, reg_we=1 -> next cycle wb_valid=1, wb_data=7, wb_rd=5, stall never high.
- LB at 0x00001001, dm_rdata=0x11A2B3C4, ready after 3 cycles -> dm_addr=0x1000, dm_be=0100, stall for 4 cycles, wb_data=0xFFFFFFA2. Same access with LBU -> 0x000000A2.
- SB rt=0x0000005A at 0x2003 -> dm_we=1, dm_be=0001, dm_wdata=0x5A5A5A5A, wb_reg_we=0. SH 0xBEEF at 0x2002 -> be=0011, wdata=0xBEEFBEEF.
- LW at 0x00003002 -> misalign pulse, dm_req never asserted, wb_valid=1, wb_reg_we=0.
- LW with dm_ready held low, TIMEOUT=64 -> dm_req high 64 cycles then drops, bus_err pulse, back to IDLE.
- reset_n low for 1 cycle mid-ACCESS -> dm_req and stall 0 immediately. A following ADD completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS datapath: access sizes, memory-stage states,
// load/store opcodes and the access alignment rule.
package mips_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

    // Size 11 is never legal; halves need an even offset, words offset 0.
    function automatic logic access_aligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_WORD: return offset == 2'b00;
            SZ_HALF: return !offset[0];
            SZ_BYTE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Big-endian lane steering: in load mode extracts and extends a lane of data,
// in store mode replicates store data across lanes; be is produced in both.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic        store_mode,
    output logic [31:0] data_out,
    output logic [3:0]  be
);

    function automatic logic [31:0] extend_byte(input logic [7:0] v, input logic zx);
        logic signed [7:0]  s;
        logic signed [31:0] r;
        s = v;
        r = 32'(s);
        return zx ? {24'h0, v} : r;
    endfunction

    function automatic logic [31:0] extend_half(input logic [15:0] v, input logic zx);
        logic signed [15:0] s;
        logic signed [31:0] r;
        s = v;
        r = 32'(s);
        return zx ? {16'h0, v} : r;
    endfunction

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = data[31:24];
            2'd1:    byte_lane = data[23:16];
            2'd2:    byte_lane = data[15:8];
            default: byte_lane = data[7:0];
        endcase
        half_lane = offset[1] ? data[15:0] : data[31:16];
    end

    always_comb begin
        case (size)
            SZ_WORD: be = 4'b1111;
            SZ_HALF: be = offset[1] ? 4'b0011 : 4'b1100;
            SZ_BYTE: be = 4'b1000 >> offset;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        data_out = data;
        if (store_mode) begin
            case (size)
                SZ_HALF: data_out = {2{data[15:0]}};
                SZ_BYTE: data_out = {4{data[7:0]}};
                default: data_out = data;
            endcase
        end else begin
            case (size)
                SZ_HALF: data_out = extend_half(half_lane, is_unsigned);
                SZ_BYTE: data_out = extend_byte(byte_lane, is_unsigned);
                default: data_out = data;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues word/half/byte accesses over a req/ready data
// memory port, stalls execute while busy and registers the writeback result.
module mem_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic [31:0]       ex_alu_out,
    input  logic [31:0]       ex_rt_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_access_size,
    input  logic              ex_load_unsigned,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_we,
    output logic              stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic [3:0]        dm_be,
    input  logic              dm_ready,
    input  logic [31:0]       dm_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_we,
    output logic              misalign,
    output logic              bus_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               wb_valid_n, wb_reg_we_n, misalign_n, bus_err_n;
    logic [31:0]        wb_data_n;
    logic [4:0]         wb_rd_n;

    logic [31:0]        addr_p1, wdata_p1;
    logic [1:0]         size_p1;
    logic               unsigned_p1, store_p1, reg_we_p1;
    logic [4:0]         rd_p1;

    logic               mem_op, aligned, accept, launch, in_access;
    logic [31:0]        store_data, load_data;
    logic [3:0]         store_be, load_be;

    assign mem_op    = ex_mem_read | ex_mem_write;
    assign aligned   = access_aligned(ex_access_size, ex_alu_out[1:0]);
    // RESP frees the stage, so a new instruction can be taken there too.
    assign accept    = reset_n && ex_valid && (state != ST_ACCESS);
    assign launch    = accept && mem_op && aligned;
    assign in_access = (state == ST_ACCESS);

    assign stall    = launch || in_access;
    assign dm_req   = in_access;
    assign dm_we    = in_access && store_p1;
    assign dm_addr  = in_access ? {addr_p1[ADDR_W-1:2], 2'b00} : '0;
    assign dm_wdata = in_access ? store_data : '0;
    assign dm_be    = in_access ? (store_p1 ? store_be : load_be) : 4'b0000;

    load_align u_store_lane (
        .data        (wdata_p1),
        .offset      (addr_p1[1:0]),
        .size        (size_p1),
        .is_unsigned (1'b0),
        .store_mode  (1'b1),
        .data_out    (store_data),
        .be          (store_be)
    );

    load_align u_load_lane (
        .data        (dm_rdata),
        .offset      (addr_p1[1:0]),
        .size        (size_p1),
        .is_unsigned (unsigned_p1),
        .store_mode  (1'b0),
        .data_out    (load_data),
        .be          (load_be)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        wb_valid_n  = 1'b0;
        wb_reg_we_n = 1'b0;
        wb_data_n   = wb_data;
        wb_rd_n     = wb_rd;
        misalign_n  = 1'b0;
        bus_err_n   = 1'b0;
        case (state)
            ST_IDLE, ST_RESP: begin
                state_n = ST_IDLE;
                if (accept) begin
                    if (!mem_op) begin
                        wb_valid_n  = 1'b1;
                        wb_data_n   = ex_alu_out;
                        wb_rd_n     = ex_rd;
                        wb_reg_we_n = ex_reg_we;
                    end else if (!aligned) begin
                        misalign_n = 1'b1;
                        wb_valid_n = 1'b1;
                        wb_data_n  = ex_alu_out;
                        wb_rd_n    = ex_rd;
                    end else begin
                        state_n = ST_ACCESS;
                        cnt_n   = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (dm_ready) begin
                    state_n     = ST_RESP;
                    wb_valid_n  = 1'b1;
                    wb_rd_n     = rd_p1;
                    wb_data_n   = store_p1 ? addr_p1 : load_data;
                    wb_reg_we_n = reg_we_p1;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_n    = ST_IDLE;
                    bus_err_n  = 1'b1;
                    wb_valid_n = 1'b1;
                    wb_rd_n    = rd_p1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wb_valid  <= 1'b0;
            wb_reg_we <= 1'b0;
            wb_data   <= '0;
            wb_rd     <= '0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wb_valid  <= wb_valid_n;
            wb_reg_we <= wb_reg_we_n;
            wb_data   <= wb_data_n;
            wb_rd     <= wb_rd_n;
            misalign  <= misalign_n;
            bus_err   <= bus_err_n;
        end
    end

    // Access context captured at accept; stores never write a register
    always_ff @(posedge clock) begin
        if (launch) begin
            addr_p1     <= ex_alu_out;
            wdata_p1    <= ex_rt_data;
            size_p1     <= ex_access_size;
            unsigned_p1 <= ex_load_unsigned;
            store_p1    <= ex_mem_write;
            rd_p1       <= ex_rd;
            reg_we_p1   <= ex_reg_we & ~ex_mem_write;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: fixed vector table, hand-written multi-cycle sequences
// and randomized operations compared against a lane-arithmetic reference model.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_alu_out = '0;
    logic [31:0] ex_rt_data = '0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [1:0]  ex_access_size = '0;
    logic        ex_load_unsigned = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_we = 1'b0;
    logic        stall, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ready = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        wb_valid, wb_reg_we, misalign, bus_err;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    mem_stage #(.ADDR_W(32), .TIMEOUT(64)) dut (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
        .ex_rt_data(ex_rt_data), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_access_size(ex_access_size), .ex_load_unsigned(ex_load_unsigned), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .stall(stall), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_ready(dm_ready),
        .dm_rdata(dm_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_we(wb_reg_we), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rt;
        logic        mr;
        logic        mw;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rd;
        logic        rwe;
        logic [31:0] rdata;
        int          ra;     // ACCESS cycle in which dm_ready rises; 0 = never
    } op_t;

    typedef struct {
        bit          chk_data;
        logic [31:0] data;
        bit          we;
        logic [4:0]  rd;
        int          mis;
        int          stall;
        int          lat;
        int          req;
        logic [31:0] addr;
        logic [3:0]  be;
        bit          dmwe;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic [31:0] wb_data;
        logic        wb_we;
        logic [4:0]  wb_rd;
        int          wb_cnt;
        int          mis_cnt;
        int          err_cnt;
        int          stall_cyc;
        int          req_cyc;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        dmwe;
        logic [31:0] wdata;
        int          lat;
        bit          timed_out;
    } obs_t;

    typedef struct {
        op_t  op;
        exp_t e;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        else
            n_pass++;
    endtask

    // Issue one instruction for a single cycle and watch the stage until its
    // writeback appears, acting as the data memory meanwhile.
    task automatic run_op(input op_t op, output obs_t o);
        int acc;
        bit done;
        o = '{default: '0};
        acc = 0;
        done = 1'b0;
        @(negedge clock);
        ex_valid = 1'b1;
        ex_alu_out = op.alu;
        ex_rt_data = op.rt;
        ex_mem_read = op.mr;
        ex_mem_write = op.mw;
        ex_access_size = op.size;
        ex_load_unsigned = op.uns;
        ex_rd = op.rd;
        ex_reg_we = op.rwe;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            if (cyc > 0 && wb_valid) begin
                o.wb_cnt++;
                o.wb_data = wb_data;
                o.wb_we = wb_reg_we;
                o.wb_rd = wb_rd;
                o.lat = cyc;
                done = 1'b1;
            end
            if (misalign) o.mis_cnt++;
            if (bus_err) o.err_cnt++;
            if (stall) o.stall_cyc++;
            if (dm_req) begin
                o.req_cyc++;
                o.addr = dm_addr;
                o.be = dm_be;
                o.dmwe = dm_we;
                o.wdata = dm_wdata;
                acc++;
                dm_ready = (acc == op.ra);
                dm_rdata = op.rdata;
            end else begin
                dm_ready = 1'b0;
            end
            @(negedge clock);
            ex_valid = 1'b0;
        end
        if (!done) o.timed_out = 1'b1;
        #1;
        if (wb_valid) o.wb_cnt++;
        if (misalign) o.mis_cnt++;
        if (bus_err) o.err_cnt++;
        dm_ready = 1'b0;
    endtask

    task automatic check_obs(input string tag, input obs_t o, input exp_t e);
        chk({tag, "_finished"}, 32'(o.timed_out), 32'(0));
        chk({tag, "_wb_cnt"}, 32'(o.wb_cnt), 32'(1));
        chk({tag, "_wb_we"}, 32'(o.wb_we), 32'(e.we));
        chk({tag, "_misalign"}, 32'(o.mis_cnt), 32'(e.mis));
        chk({tag, "_bus_err"}, 32'(o.err_cnt), 32'(0));
        chk({tag, "_stall"}, 32'(o.stall_cyc), 32'(e.stall));
        chk({tag, "_latency"}, 32'(o.lat), 32'(e.lat));
        chk({tag, "_req_cyc"}, 32'(o.req_cyc), 32'(e.req));
        if (e.chk_data) chk({tag, "_wb_data"}, o.wb_data, e.data);
        if (e.we) chk({tag, "_wb_rd"}, 32'(o.wb_rd), 32'(e.rd));
        if (e.req > 0) begin
            chk({tag, "_dm_addr"}, o.addr, e.addr);
            chk({tag, "_dm_be"}, 32'(o.be), 32'(e.be));
            chk({tag, "_dm_we"}, 32'(o.dmwe), 32'(e.dmwe));
            if (e.dmwe) chk({tag, "_dm_wdata"}, o.wdata, e.wdata);
        end
    endtask

    // Reference model: lanes found by shifting from the most significant end.
    function automatic exp_t model(input op_t op);
        exp_t e;
        int o;
        int nbytes;
        int unsigned v;
        bit legal;
        e = '{default: '0};
        o = int'(op.alu[1:0]);
        e.rd = op.rd;
        legal = (op.size == 2'd0 && o == 0) || (op.size == 2'd1 && o % 2 == 0) || (op.size == 2'd2);
        if (!(op.mr || op.mw)) begin
            e.chk_data = 1'b1; e.data = op.alu; e.we = op.rwe; e.lat = 1;
        end else if (!legal) begin
            e.mis = 1; e.lat = 1;
        end else begin
            e.stall = 1 + op.ra;
            e.req = op.ra;
            e.lat = 1 + op.ra;
            e.addr = op.alu & 32'hFFFF_FFFC;
            e.dmwe = op.mw;
            nbytes = (op.size == 2'd0) ? 4 : (op.size == 2'd1) ? 2 : 1;
            e.be = 4'(((1 << nbytes) - 1) << (4 - nbytes - o));
            e.chk_data = 1'b1;
            if (op.mw) begin
                e.data = op.alu;
                e.we = 1'b0;
                e.wdata = (nbytes == 4) ? op.rt :
                          (nbytes == 2) ? {16'h0, op.rt[15:0]} * 32'h0001_0001 :
                                          {24'h0, op.rt[7:0]} * 32'h0101_0101;
            end else begin
                e.we = op.rwe;
                if (nbytes == 4) begin
                    v = op.rdata;
                end else begin
                    v = (op.rdata >> (8 * (4 - nbytes - o))) & ((32'd1 << (8 * nbytes)) - 32'd1);
                    if (!op.uns && v >= (32'd1 << (8 * nbytes - 1))) v = v - (32'd1 << (8 * nbytes));
                end
                e.data = v;
            end
        end
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        obs_t o;
        op_t  op;
        exp_t e;

        vecs[0]  = '{'{32'h7, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd5, 1'b1, 32'h0, 0},
                     '{1'b1, 32'h7, 1'b1, 5'd5, 0, 0, 1, 0, 32'h0, 4'h0, 1'b0, 32'h0}};
        vecs[1]  = '{'{32'h1001, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd8, 1'b1, 32'h11A2B3C4, 3},
                     '{1'b1, 32'hFFFFFFA2, 1'b1, 5'd8, 0, 4, 4, 3, 32'h1000, 4'b0100, 1'b0, 32'h0}};
        vecs[2]  = '{'{32'h1001, 32'h0, 1'b1, 1'b0, 2'd2, 1'b1, 5'd8, 1'b1, 32'h11A2B3C4, 3},
                     '{1'b1, 32'h000000A2, 1'b1, 5'd8, 0, 4, 4, 3, 32'h1000, 4'b0100, 1'b0, 32'h0}};
        vecs[3]  = '{'{32'h2003, 32'h5A, 1'b0, 1'b1, 2'd2, 1'b0, 5'd3, 1'b0, 32'h0, 1},
                     '{1'b1, 32'h2003, 1'b0, 5'd3, 0, 2, 2, 1, 32'h2000, 4'b0001, 1'b1, 32'h5A5A5A5A}};
        vecs[4]  = '{'{32'h2002, 32'hBEEF, 1'b0, 1'b1, 2'd1, 1'b0, 5'd3, 1'b0, 32'h0, 2},
                     '{1'b1, 32'h2002, 1'b0, 5'd3, 0, 3, 3, 2, 32'h2000, 4'b0011, 1'b1, 32'hBEEFBEEF}};
        vecs[5]  = '{'{32'h3002, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd4, 1'b1, 32'h0, 1},
                     '{1'b0, 32'h0, 1'b0, 5'd4, 1, 0, 1, 0, 32'h0, 4'h0, 1'b0, 32'h0}};
        vecs[6]  = '{'{32'h1002, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd6, 1'b1, 32'h12348001, 1},
                     '{1'b1, 32'hFFFF8001, 1'b1, 5'd6, 0, 2, 2, 1, 32'h1000, 4'b0011, 1'b0, 32'h0}};
        vecs[7]  = '{'{32'h1000, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1, 5'd7, 1'b1, 32'h9ABC0000, 2},
                     '{1'b1, 32'h00009ABC, 1'b1, 5'd7, 0, 3, 3, 2, 32'h1000, 4'b1100, 1'b0, 32'h0}};
        vecs[8]  = '{'{32'h1004, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd9, 1'b1, 32'hDEADBEEF, 1},
                     '{1'b1, 32'hDEADBEEF, 1'b1, 5'd9, 0, 2, 2, 1, 32'h1004, 4'b1111, 1'b0, 32'h0}};
        vecs[9]  = '{'{32'h1000, 32'h0, 1'b1, 1'b0, 2'd3, 1'b0, 5'd10, 1'b1, 32'h0, 1},
                     '{1'b0, 32'h0, 1'b0, 5'd10, 1, 0, 1, 0, 32'h0, 4'h0, 1'b0, 32'h0}};
        vecs[10] = '{'{32'h3000, 32'hCAFEF00D, 1'b1, 1'b1, 2'd0, 1'b0, 5'd11, 1'b1, 32'h0, 1},
                     '{1'b1, 32'h3000, 1'b0, 5'd11, 0, 2, 2, 1, 32'h3000, 4'b1111, 1'b1, 32'hCAFEF00D}};
        vecs[11] = '{'{32'h1000, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd12, 1'b1, 32'h7F000000, 1},
                     '{1'b1, 32'h0000007F, 1'b1, 5'd12, 0, 2, 2, 1, 32'h1000, 4'b1000, 1'b0, 32'h0}};
        vecs[12] = '{'{32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 32'h0, 0},
                     '{1'b1, 32'hFFFFFFFF, 1'b0, 5'd0, 0, 0, 1, 0, 32'h0, 4'h0, 1'b0, 32'h0}};

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("rst_ctrl", 32'({stall, dm_req, dm_we, wb_valid, wb_reg_we, misalign, bus_err}), 32'(0));
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_bus", {dm_wdata[27:0], dm_be}, 32'h0);
        chk("rst_wb", {wb_data[26:0], wb_rd}, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, o);
            check_obs($sformatf("vec%0d", i), o, vecs[i].e);
        end

        // Timeout: dm_ready never rises
        op = '{32'h4000, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd13, 1'b1, 32'h0, 0};
        run_op(op, o);
        chk("to_finished", 32'(o.timed_out), 32'(0));
        chk("to_req_cyc", 32'(o.req_cyc), 32'(64));
        chk("to_bus_err", 32'(o.err_cnt), 32'(1));
        chk("to_wb_cnt", 32'(o.wb_cnt), 32'(1));
        chk("to_wb_we", 32'(o.wb_we), 32'(0));
        chk("to_misalign", 32'(o.mis_cnt), 32'(0));
        chk("to_latency", 32'(o.lat), 32'(65));

        // Back-to-back: an ADD held during ACCESS is taken in the RESP cycle
        @(negedge clock);
        ex_valid = 1'b1; ex_alu_out = 32'h1008; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_access_size = 2'd0; ex_rd = 5'd14; ex_reg_we = 1'b1; dm_rdata = 32'h0BADF00D;
        #1 chk("b2b_accept_stall", 32'(stall), 32'(1));
        @(negedge clock);
        ex_alu_out = 32'h55; ex_mem_read = 1'b0; ex_rd = 5'd9;
        #1 chk("b2b_access_stall", 32'({stall, dm_req}), 32'(3));
        @(negedge clock);
        #1 chk("b2b_access2_req", 32'(dm_req), 32'(1));
        dm_ready = 1'b1;
        @(negedge clock);
        dm_ready = 1'b0;
        #1;
        chk("b2b_resp", 32'({wb_valid, wb_reg_we, stall, dm_req}), 32'(4'b1100));
        chk("b2b_resp_data", wb_data, 32'h0BADF00D);
        @(negedge clock);
        ex_valid = 1'b0;
        #1;
        chk("b2b_add_valid", 32'({wb_valid, wb_reg_we, wb_rd}), 32'({2'b11, 5'd9}));
        chk("b2b_add_data", wb_data, 32'h55);
        @(negedge clock);
        #1 chk("b2b_idle", 32'(wb_valid), 32'(0));

        // Reset asserted mid-ACCESS
        @(negedge clock);
        ex_valid = 1'b1; ex_alu_out = 32'h1008; ex_mem_read = 1'b1; ex_access_size = 2'd0;
        ex_rd = 5'd15; ex_reg_we = 1'b1;
        @(negedge clock);
        ex_valid = 1'b0;
        @(negedge clock);
        #1 chk("rma_req_before", 32'(dm_req), 32'(1));
        #1 reset_n = 1'b0;
        #1 chk("rma_req_stall", 32'({dm_req, stall}), 32'(0));
        @(negedge clock);
        reset_n = 1'b1;
        #1 chk("rma_after_release", 32'({dm_req, stall, wb_valid}), 32'(0));
        op = '{32'h1234, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd16, 1'b1, 32'h0, 0};
        run_op(op, o);
        check_obs("rma_add", o, model(op));

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            op.alu = $urandom;
            op.rt = $urandom;
            op.mr = (kind == 1 || kind == 3);
            op.mw = (kind == 2 || kind == 3);
            op.size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            op.uns = 1'($urandom_range(0, 1));
            op.rd = 5'($urandom_range(0, 31));
            op.rwe = 1'($urandom_range(0, 1));
            op.rdata = $urandom;
            op.ra = $urandom_range(1, 3);
            if ($urandom_range(0, 2) != 0) begin
                if (op.size == 2'd0) op.alu[1:0] = 2'b00;
                else if (op.size == 2'd1) op.alu[0] = 1'b0;
            end
            e = model(op);
            run_op(op, o);
            check_obs($sformatf("rnd%0d", i), o, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
